// File: rtl/add_fu_sched_if.sv
// add_fu_sched_if: issue, reservation-station, adder and CDB signals of the add-class scheduler
interface add_fu_sched_if #(
  parameter int NUM_RS = 3
);
  logic              issue_valid;
  logic              issue_ready;
  logic [3:0]        issue_tag;
  logic [NUM_RS-1:0] rs_sel;
  logic [NUM_RS-1:0] rs_busy;
  logic [NUM_RS-1:0] rs_ready;
  logic              fu_start;
  logic [NUM_RS-1:0] fu_sel;
  logic              cdb_req;
  logic              cdb_grant;
  logic [3:0]        cdb_tag;
  logic [NUM_RS-1:0] rs_release;
  modport master (
    input  issue_valid, rs_busy, rs_ready, cdb_grant,
    output issue_ready, issue_tag, rs_sel, fu_start, fu_sel, cdb_req, cdb_tag, rs_release
  );
  modport slave (
    output issue_valid, rs_busy, rs_ready, cdb_grant,
    input  issue_ready, issue_tag, rs_sel, fu_start, fu_sel, cdb_req, cdb_tag, rs_release
  );
endinterface

// File: rtl/add_fu_sched.sv
// add_fu_sched: allocates add RS entries, dispatches one ready entry round-robin, times the adder and writes back on the CDB
module add_fu_sched #(
  parameter int NUM_RS   = 3,
  parameter int TAG_BASE = 1,
  parameter int LAT      = 2
) (
  input logic            clk,
  input logic            rst_n,
  add_fu_sched_if.master bus
);
  localparam int PW  = $clog2(NUM_RS);
  localparam int PW1 = PW + 1;
  localparam int CW  = $clog2(LAT + 1);
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  state_t            state, state_nx;
  logic [PW-1:0]     rr_ptr, rr_nx, cur, cur_nx, pick, low_free;
  logic [PW:0]       idx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [NUM_RS-1:0] free, cand, cur_oh;
  logic              found;
  assign free            = ~bus.rs_busy;
  assign bus.issue_ready = |free;
  assign bus.issue_tag   = bus.issue_ready ? 4'(TAG_BASE) + 4'(low_free) : 4'd0;
  assign bus.rs_sel      = (bus.issue_valid && bus.issue_ready) ? NUM_RS'(1) << low_free : '0;
  assign cur_oh          = NUM_RS'(1) << cur;
  assign bus.fu_sel      = (state == IDLE) ? '0 : cur_oh;
  assign cand            = bus.rs_busy & bus.rs_ready & ~bus.fu_sel;
  assign bus.fu_start    = (state == EXEC) && (cnt == CW'(LAT - 1));
  assign bus.cdb_req     = (state == WB);
  assign bus.cdb_tag     = bus.cdb_req ? 4'(TAG_BASE) + 4'(cur) : 4'd0;
  assign bus.rs_release  = (bus.cdb_req && bus.cdb_grant) ? cur_oh : '0;
  // lowest free entry gets the next issued instruction
  always_comb begin
    low_free = '0;
    for (int i = NUM_RS - 1; i >= 0; i--) low_free = free[i] ? PW'(i) : low_free;
  end
  // first candidate at or above rr_ptr, wrapping past the last entry
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      idx = {1'b0, rr_ptr} + PW1'(k);
      idx = (idx >= PW1'(NUM_RS)) ? idx - PW1'(NUM_RS) : idx;
      if (!found && cand[idx[PW-1:0]]) begin
        pick  = idx[PW-1:0];
        found = 1'b1;
      end
    end
  end
  // next-state: dispatch in IDLE, count latency in EXEC, wait for grant in WB
  always_comb begin
    state_nx = state;
    rr_nx    = rr_ptr;
    cur_nx   = cur;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (found) begin
        state_nx = EXEC;
        cur_nx   = pick;
        rr_nx    = (pick == PW'(NUM_RS - 1)) ? '0 : pick + PW'(1);
        cnt_nx   = CW'(LAT - 1);
      end
      EXEC: if (cnt == '0) state_nx = WB;
            else cnt_nx = cnt - CW'(1);
      WB:   state_nx = bus.cdb_grant ? IDLE : WB;
      default: state_nx = IDLE;
    endcase
  end
  // state register; reset drops any in-flight op without releasing it
  always_ff @(posedge clk)
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      cur    <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nx;
      rr_ptr <= rr_nx;
      cur    <= cur_nx;
      cnt    <= cnt_nx;
    end
endmodule
